// File: rtl/bpu_pkg.sv
// Shared types and helpers for the branch prediction unit.
package bpu_pkg;

   // Resolved control-flow class reported by the branch unit.
   typedef enum logic [1:0] {
      UPD_COND = 2'b00,
      UPD_JUMP = 2'b01,
      UPD_RET  = 2'b10,
      UPD_RSVD = 2'b11
   } upd_type_e;

   // Two-bit direction counter states; bit 1 is the taken prediction.
   localparam logic [1:0] CTR_SNT = 2'b00;
   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_WT  = 2'b10;
   localparam logic [1:0] CTR_ST  = 2'b11;

   // Fixed-width part of a BTB entry. The tag and target widths depend on
   // the top-level parameters, so those fields are kept in parallel
   // arrays inside bpu, indexed the same way as this struct.
   typedef struct packed {
      logic      valid;
      upd_type_e typ;
      logic [1:0] ctr;
   } btb_entry_t;

   // Saturating up/down step of the direction counter.
   function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      nxt = ctr;
      if (taken) begin
         if (ctr != CTR_ST) nxt = ctr + 2'b01;
         else               nxt = ctr;
      end else begin
         if (ctr != CTR_SNT) nxt = ctr - 2'b01;
         else                nxt = ctr;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bpu_ras.sv
// Circular return address stack, updated only at branch resolution.
// A pop on empty is dropped; a push on full overwrites the oldest entry.
module bpu_ras #(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  logic [XLEN-1:0] push_addr,
   output logic [XLEN-1:0] top,
   output logic            empty
);

   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [XLEN-1:0]  stack_r [RAS_DEPTH];
   logic [PTR_W-1:0] ptr_r, ptr_pop_s, ptr_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_pop_s, cnt_nxt_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? PTR_ZERO : p + PTR_ONE;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
      return (p == PTR_ZERO) ? PTR_LAST : p - PTR_ONE;
   endfunction

   // Next pointer/count: apply the pop first, then the push, so a combined
   // return-and-call replaces the top without changing the depth.
   always_comb begin
      ptr_pop_s = ptr_r;
      cnt_pop_s = cnt_r;
      if (pop && (cnt_r != CNT_ZERO)) begin
         ptr_pop_s = ptr_dec(ptr_r);
         cnt_pop_s = cnt_r - CNT_ONE;
      end else begin
         ptr_pop_s = ptr_r;
         cnt_pop_s = cnt_r;
      end
      ptr_nxt_s = ptr_pop_s;
      cnt_nxt_s = cnt_pop_s;
      if (push) begin
         ptr_nxt_s = ptr_inc(ptr_pop_s);
         if (cnt_pop_s != CNT_FULL) cnt_nxt_s = cnt_pop_s + CNT_ONE;
         else                       cnt_nxt_s = cnt_pop_s;
      end else begin
         ptr_nxt_s = ptr_pop_s;
         cnt_nxt_s = cnt_pop_s;
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_r <= PTR_ZERO;
         cnt_r <= CNT_ZERO;
      end else begin
         ptr_r <= ptr_nxt_s;
         cnt_r <= cnt_nxt_s;
      end
   end

   // Stack storage; contents are meaningless while the count is zero.
   always_ff @(posedge clk) begin
      if (push) stack_r[ptr_nxt_s] <= push_addr;
   end

   assign top   = stack_r[ptr_r];
   assign empty = (cnt_r == CNT_ZERO);

endmodule

// File: rtl/bpu.sv
// Branch prediction unit: direct-mapped BTB with 2-bit direction counters
// and a return address stack. Lookup is combinational from registered
// state; training from the EX stage takes effect on the next cycle.
module bpu
   import bpu_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BTB_DEPTH = 16,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   input  logic [XLEN-1:0] if_pc,
   output logic            pred_take,
   output logic [XLEN-1:0] pred_pc,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic [1:0]      upd_type,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_is_call,
   input  logic            upd_pred_take,
   input  logic [XLEN-1:0] upd_pred_pc,
   output logic            mispredict
);

   localparam int IDX_W = $clog2(BTB_DEPTH);
   localparam int TAG_W = XLEN - 2 - IDX_W;

   btb_entry_t       btb_meta_r [BTB_DEPTH];
   logic [TAG_W-1:0] btb_tag_r  [BTB_DEPTH];
   logic [XLEN-1:0]  btb_tgt_r  [BTB_DEPTH];

   logic [IDX_W-1:0] if_idx_s, upd_idx_s;
   logic [TAG_W-1:0] if_tag_s, upd_tag_s;
   btb_entry_t       if_ent_s, upd_ent_s, wr_meta_s;
   logic             if_hit_s, upd_hit_s, wr_en_s;
   logic [XLEN-1:0]  wr_tgt_s;
   logic             ras_push_s, ras_pop_s, ras_empty_s;
   logic [XLEN-1:0]  ras_top_s;
   logic             unused_pc_bits_s;

   // Instruction alignment bits never take part in indexing.
   assign unused_pc_bits_s = ^if_pc[1:0];

   assign if_idx_s  = if_pc[2 +: IDX_W];
   assign if_tag_s  = if_pc[XLEN-1 -: TAG_W];
   assign if_ent_s  = btb_meta_r[if_idx_s];
   assign if_hit_s  = if_valid && if_ent_s.valid && (btb_tag_r[if_idx_s] == if_tag_s);

   assign upd_idx_s = upd_pc[2 +: IDX_W];
   assign upd_tag_s = upd_pc[XLEN-1 -: TAG_W];
   assign upd_ent_s = btb_meta_r[upd_idx_s];
   assign upd_hit_s = upd_ent_s.valid && (btb_tag_r[upd_idx_s] == upd_tag_s);

   // Fetch-side prediction; returns prefer the stack top when it holds data.
   always_comb begin
      pred_take = 1'b0;
      pred_pc   = {XLEN{1'b0}};
      if (if_hit_s) begin
         case (if_ent_s.typ)
            UPD_COND:          pred_take = if_ent_s.ctr[1];
            UPD_JUMP, UPD_RET: pred_take = 1'b1;
            default:           pred_take = 1'b0;
         endcase
         if ((if_ent_s.typ == UPD_RET) && !ras_empty_s) pred_pc = ras_top_s;
         else                                           pred_pc = btb_tgt_r[if_idx_s];
      end else begin
         pred_take = 1'b0;
         pred_pc   = {XLEN{1'b0}};
      end
   end

   // Training decision: what, if anything, gets written to the indexed entry.
   always_comb begin
      wr_en_s   = 1'b0;
      wr_meta_s = upd_ent_s;
      wr_tgt_s  = btb_tgt_r[upd_idx_s];
      if (upd_valid) begin
         case (upd_type)
            UPD_COND: begin
               if (upd_hit_s) begin
                  wr_en_s       = 1'b1;
                  wr_meta_s.ctr = ctr_next(upd_ent_s.ctr, upd_taken);
                  if (upd_taken) wr_tgt_s = upd_target;
                  else           wr_tgt_s = btb_tgt_r[upd_idx_s];
               end else if (upd_taken) begin
                  wr_en_s         = 1'b1;
                  wr_meta_s.valid = 1'b1;
                  wr_meta_s.typ   = UPD_COND;
                  wr_meta_s.ctr   = CTR_WT;
                  wr_tgt_s        = upd_target;
               end else begin
                  wr_en_s = 1'b0;
               end
            end
            UPD_JUMP, UPD_RET: begin
               if (upd_hit_s) begin
                  wr_en_s       = 1'b1;
                  wr_meta_s.typ = upd_type_e'(upd_type);
                  wr_tgt_s      = upd_target;
               end else if (upd_taken) begin
                  wr_en_s         = 1'b1;
                  wr_meta_s.valid = 1'b1;
                  wr_meta_s.typ   = upd_type_e'(upd_type);
                  wr_meta_s.ctr   = CTR_ST;
                  wr_tgt_s        = upd_target;
               end else begin
                  wr_en_s = 1'b0;
               end
            end
            default: wr_en_s = 1'b0;
         endcase
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Entry metadata; valid bits are cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BTB_DEPTH; i++) begin
            btb_meta_r[i].valid <= 1'b0;
            btb_meta_r[i].typ   <= UPD_COND;
            btb_meta_r[i].ctr   <= CTR_SNT;
         end
      end else if (wr_en_s) begin
         btb_meta_r[upd_idx_s] <= wr_meta_s;
      end
   end

   // Tag and target storage, qualified by the valid bit.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         btb_tag_r[upd_idx_s] <= upd_tag_s;
         btb_tgt_r[upd_idx_s] <= wr_tgt_s;
      end
   end

   assign ras_pop_s  = upd_valid && (upd_type == UPD_RET);
   assign ras_push_s = upd_valid && upd_is_call && (upd_type != UPD_RSVD);

   bpu_ras #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (ras_push_s),
      .pop       (ras_pop_s),
      .push_addr (upd_pc + XLEN'(4)),
      .top       (ras_top_s),
      .empty     (ras_empty_s)
   );

   assign mispredict = upd_valid &&
                       ((upd_taken != upd_pred_take) ||
                        (upd_taken && (upd_target != upd_pred_pc)));

endmodule

// File: tb/tb_bpu.sv
// Directed bench for bpu: one-cycle vectors that drive a lookup and an
// update together and check the combinational outputs before the edge.
module tb_bpu;

   localparam logic [1:0] T_COND = 2'b00;
   localparam logic [1:0] T_JUMP = 2'b01;
   localparam logic [1:0] T_RET  = 2'b10;
   localparam logic [1:0] T_RSVD = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic [31:0] if_pc;
   logic        pred_take;
   logic [31:0] pred_pc;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [1:0]  upd_type;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_is_call;
   logic        upd_pred_take;
   logic [31:0] upd_pred_pc;
   logic        mispredict;

   bpu #(.XLEN(32), .BTB_DEPTH(16), .RAS_DEPTH(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .pred_take     (pred_take),
      .pred_pc       (pred_pc),
      .upd_valid     (upd_valid),
      .upd_pc        (upd_pc),
      .upd_type      (upd_type),
      .upd_taken     (upd_taken),
      .upd_target    (upd_target),
      .upd_is_call   (upd_is_call),
      .upd_pred_take (upd_pred_take),
      .upd_pred_pc   (upd_pred_pc),
      .mispredict    (mispredict)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        lv;
      logic [31:0] lpc;
      logic        uv;
      logic [31:0] upc;
      logic [1:0]  ut;
      logic        tk;
      logic [31:0] tgt;
      logic        call;
      logic        ppt;
      logic [31:0] ppc;
      logic        e_take;
      logic [31:0] e_pc;
      logic        pc_dc;   // pred_pc not checked (hit but predicted not-taken)
      logic        e_mis;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(string name, logic lv, logic [31:0] lpc,
                               logic uv, logic [31:0] upc, logic [1:0] ut, logic tk,
                               logic [31:0] tgt, logic call, logic ppt, logic [31:0] ppc,
                               logic e_take, logic [31:0] e_pc, logic pc_dc, logic e_mis);
      vec_t v;
      v.name = name; v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut;
      v.tk = tk; v.tgt = tgt; v.call = call; v.ppt = ppt; v.ppc = ppc;
      v.e_take = e_take; v.e_pc = e_pc; v.pc_dc = pc_dc; v.e_mis = e_mis;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      if_valid      = v.lv;
      if_pc         = v.lpc;
      upd_valid     = v.uv;
      upd_pc        = v.upc;
      upd_type      = v.ut;
      upd_taken     = v.tk;
      upd_target    = v.tgt;
      upd_is_call   = v.call;
      upd_pred_take = v.ppt;
      upd_pred_pc   = v.ppc;
      #2;
      check({v.name, "/pred_take"}, {31'd0, pred_take}, {31'd0, v.e_take});
      if (!v.pc_dc) check({v.name, "/pred_pc"}, pred_pc, v.e_pc);
      check({v.name, "/mispredict"}, {31'd0, mispredict}, {31'd0, v.e_mis});
      @(posedge clk);
      #1;
   endtask

   logic [31:0] call_pc [5];
   logic [31:0] pop_exp [5];

   initial begin
      rst = 1'b1;
      if_valid = 1'b0; if_pc = 32'd0; upd_valid = 1'b0; upd_pc = 32'd0;
      upd_type = T_COND; upd_taken = 1'b0; upd_target = 32'd0; upd_is_call = 1'b0;
      upd_pred_take = 1'b0; upd_pred_pc = 32'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      //        name             lv   lpc           uv   upc           type    tk   tgt           call ppt  ppc           take pc            dc   mis
      tbl.push_back(mk("rst_idle",     1'b0, 32'h0,   1'b0, 32'h0,   T_COND, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0));
      tbl.push_back(mk("cold_lookup",  1'b1, 32'h100, 1'b0, 32'h0,   T_COND, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0));
      tbl.push_back(mk("cond_train",   1'b1, 32'h100, 1'b1, 32'h100, T_COND, 1'b1, 32'h80,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1));
      tbl.push_back(mk("cond_hit",     1'b1, 32'h100, 1'b0, 32'h0,   T_COND, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 1'b0));
      tbl.push_back(mk("same_cyc_nt1", 1'b1, 32'h100, 1'b1, 32'h100, T_COND, 1'b0, 32'h104, 1'b0, 1'b1, 32'h80,  1'b1, 32'h80,  1'b0, 1'b1));
      tbl.push_back(mk("cond_nt2",     1'b1, 32'h100, 1'b1, 32'h100, T_COND, 1'b0, 32'h104, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0));
      tbl.push_back(mk("cond_nt3",     1'b1, 32'h100, 1'b1, 32'h100, T_COND, 1'b0, 32'h104, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0));
      tbl.push_back(mk("cond_sat_tk",  1'b1, 32'h100, 1'b1, 32'h100, T_COND, 1'b1, 32'h80,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1));
      tbl.push_back(mk("cond_ctr01",   1'b1, 32'h100, 1'b0, 32'h0,   T_COND, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0));
      tbl.push_back(mk("alias_jump",   1'b1, 32'h100, 1'b1, 32'h140, T_JUMP, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1));
      tbl.push_back(mk("alias_old",    1'b1, 32'h100, 1'b0, 32'h0,   T_COND, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0));
      tbl.push_back(mk("alias_new",    1'b1, 32'h140, 1'b0, 32'h0,   T_COND, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h400, 1'b0, 1'b0));
      tbl.push_back(mk("mis_target",   1'b1, 32'h140, 1'b1, 32'h140, T_RSVD, 1'b1, 32'h80,  1'b0, 1'b1, 32'h84,  1'b1, 32'h400, 1'b0, 1'b1));
      tbl.push_back(mk("mis_match",    1'b1, 32'h140, 1'b1, 32'h140, T_RSVD, 1'b1, 32'h80,  1'b0, 1'b1, 32'h80,  1'b1, 32'h400, 1'b0, 1'b0));
      tbl.push_back(mk("mis_novalid",  1'b0, 32'h140, 1'b0, 32'h140, T_COND, 1'b1, 32'h80,  1'b0, 1'b0, 32'h84,  1'b0, 32'h0,   1'b0, 1'b0));
      tbl.push_back(mk("call_200",     1'b1, 32'h140, 1'b1, 32'h200, T_JUMP, 1'b1, 32'h300, 1'b1, 1'b1, 32'h300, 1'b1, 32'h400, 1'b0, 1'b0));
      tbl.push_back(mk("ret_train",    1'b1, 32'h200, 1'b1, 32'h300, T_RET,  1'b1, 32'h204, 1'b0, 1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 1'b1));
      tbl.push_back(mk("ret_hit",      1'b1, 32'h300, 1'b0, 32'h0,   T_COND, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 1'b0));

      foreach (tbl[i]) apply(tbl[i]);

      // Five calls into a four-deep stack, then five returns.
      call_pc[0] = 32'h1004; call_pc[1] = 32'h1014; call_pc[2] = 32'h1024;
      call_pc[3] = 32'h1034; call_pc[4] = 32'h1008;
      pop_exp[0] = 32'h100C; pop_exp[1] = 32'h1038; pop_exp[2] = 32'h1028;
      pop_exp[3] = 32'h1018; pop_exp[4] = 32'h204;
      for (int i = 0; i < 5; i++)
         apply(mk($sformatf("call%0d", i), 1'b0, 32'h0, 1'b1, call_pc[i], T_JUMP, 1'b1, 32'h2000,
                  1'b1, 1'b1, 32'h2000, 1'b0, 32'h0, 1'b0, 1'b0));
      for (int i = 0; i < 5; i++)
         apply(mk($sformatf("pop%0d", i), 1'b1, 32'h300, 1'b1, 32'h300, T_RET, 1'b1, 32'h204,
                  1'b0, 1'b1, 32'h204, 1'b1, pop_exp[i], 1'b0, 1'b0));
      apply(mk("pop_empty_kept", 1'b1, 32'h300, 1'b0, 32'h0, T_COND, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0, 1'b1, 32'h204, 1'b0, 1'b0));

      // Return that is also a call: top replaced, depth unchanged.
      apply(mk("rc_push", 1'b0, 32'h0, 1'b1, 32'h1044, T_JUMP, 1'b1, 32'h2000,
               1'b1, 1'b1, 32'h2000, 1'b0, 32'h0, 1'b0, 1'b0));
      apply(mk("rc_retcall", 1'b1, 32'h300, 1'b1, 32'h300, T_RET, 1'b1, 32'h204,
               1'b1, 1'b1, 32'h204, 1'b1, 32'h1048, 1'b0, 1'b0));
      apply(mk("rc_pop", 1'b1, 32'h300, 1'b1, 32'h300, T_RET, 1'b1, 32'h204,
               1'b0, 1'b1, 32'h204, 1'b1, 32'h304, 1'b0, 1'b0));
      apply(mk("rc_empty", 1'b1, 32'h300, 1'b0, 32'h0, T_COND, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0, 1'b1, 32'h204, 1'b0, 1'b0));

      // Asynchronous reset in the middle of a cycle after training.
      if_valid = 1'b1; if_pc = 32'h300; upd_valid = 1'b0;
      #2 rst = 1'b1;
      #1 check("rst_async/pred_take", {31'd0, pred_take}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      apply(mk("after_rst", 1'b1, 32'h300, 1'b0, 32'h0, T_COND, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0));
      apply(mk("after_rst_140", 1'b1, 32'h140, 1'b0, 32'h0, T_COND, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bpu.md
Name: bpu

Overview:
- Branch prediction unit for the veriRISCV fetch stage: direct-mapped branch target buffer (BTB), a 2-bit saturating direction counter per entry, and a return address stack (RAS).
- The IF stage looks up the predicted next PC each cycle.
- The EX stage (branch unit) reports resolved control-flow instructions; the BPU trains on them and flags mispredictions.
- Generalises the single-cycle branch resolver with configurable width, table depth and stack depth, plus persistent state.

Parameters:
- XLEN, 32, data/PC width.
- BTB_DEPTH, 16, BTB entries; power of 2, minimum 2.
- RAS_DEPTH, 4, return stack entries; minimum 1.
- Derived: IDX_W = log2(BTB_DEPTH); TAG_W = XLEN-2-IDX_W.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- if_valid  in  1  lookup request
- if_pc  in  XLEN  fetch PC
- pred_take  out  1  predicted taken
- pred_pc  out  XLEN  predicted target, valid when pred_take
- upd_valid  in  1  resolved control-flow instruction (branch/jal/jalr only)
- upd_pc  in  XLEN  its PC
- upd_type  in  2  00 COND, 01 JUMP (jal/jalr non-return), 10 RET, 11 reserved (ignored)
- upd_taken  in  1  actual outcome (1 for JUMP/RET)
- upd_target  in  XLEN  actual target, bit0 already 0
- upd_is_call  in  1  link register rd is x1/x5
- upd_pred_take  in  1  prediction carried down the pipe
- upd_pred_pc  in  XLEN  predicted target carried down the pipe
- mispredict  out  1  redirect required

Behaviour:
- Clock, reset and tables:
  - One clock; reset is asynchronous and active-high.
  - Reset clears all BTB valid bits, RAS pointer and RAS count.
  - Reset may arrive mid-operation; state is cleared immediately.
  - After reset, pred_take=0 and mispredict=0 (inputs idle).
  - BTB entry fields: valid, tag[TAG_W], target[XLEN], type[2], ctr[2].
  - Index = pc[2+:IDX_W]; tag = pc[XLEN-1:2+IDX_W]; pc[1:0] ignored.
- Lookup (combinational, zero latency, from registered state):
  - hit = if_valid & entry.valid & tag match.
  - pred_take = hit & (type==JUMP | type==RET | (type==COND & ctr[1])).
  - pred_pc = (type==RET & ras_count!=0) ? RAS top : entry.target.
  - RAS empty on RET: entry.target is used.
  - No hit: pred_take=0, pred_pc=0.
- Mispredict (combinational):
  - mispredict = upd_valid & ((upd_taken != upd_pred_take) | (upd_taken & upd_target != upd_pred_pc)).
- Update (registered; visible to lookups the cycle after upd_valid):
  - Hit COND: ctr saturating increment if taken, decrement if not (00 and 11 saturate). Target is overwritten when taken.
  - Hit JUMP/RET: target and type rewritten.
  - Miss and taken: allocate, overwriting any conflicting entry. valid=1, tag, target, type; ctr=2'b10 for COND, 2'b11 otherwise.
  - Miss and not taken: no change.
  - upd_type 11: no table or RAS change.
- RAS (circular, updated at resolution only, no speculative repair):
  - RET pops: ptr-1, count-1. Pop on empty is ignored.
  - upd_is_call pushes upd_pc+4 (wrapping XLEN add): ptr+1, count saturates at RAS_DEPTH. Push on full overwrites the oldest entry.
  - RET and call in the same update (jalr x1,x1): pop then push, so the top is replaced and count is unchanged.
- Simultaneous lookup and update to the same index: lookup returns the pre-update contents.

Decomposition:
- Package bpu_pkg holds the upd_type enum (COND/JUMP/RET), ctr constants (CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11) and the btb_entry_t struct.
- Sub-module bpu_ras (stack pointer, count, storage, push/pop, top output), parametrised by XLEN and RAS_DEPTH.

Test Plan:
- Reset, then lookup if_pc=0x100 -> pred_take=0. Assert rst mid-run after training -> next lookup pred_take=0.
- COND taken update pc=0x100 target=0x80 -> next cycle lookup 0x100 gives pred_take=1, pred_pc=0x80. Two not-taken updates -> pred_take=0 (ctr 10->01->00). Third not-taken -> ctr stays 00.
- Aliasing, BTB_DEPTH=16: train 0x100, then taken JUMP at 0x140 (same index) -> lookup 0x100 misses, 0x140 hits.
- Call/return: call at 0x200 (upd_is_call) then RET at 0x300 trained -> lookup 0x300 gives pred_pc=0x204. Five calls with RAS_DEPTH=4 -> four pops return 5th..2nd link addresses, fifth pop falls back to BTB target.
- Mispredict: upd_taken=1, upd_pred_take=1, upd_target=0x80, upd_pred_pc=0x84 -> mispredict=1. Matching values -> 0. upd_valid=0 -> 0.
- Same-cycle update and lookup at the same index -> old prediction this cycle, new prediction next cycle.
